// File: rtl/framebuffer_writer.sv
// Packs a raster stream of RGB332 pixels into 32-bit words and writes them
// to the image RAM write port, one frame per start request.
module framebuffer_writer #(
  parameter int unsigned IMG_W  = 80,
  parameter int unsigned IMG_H  = 80,
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        pix_data,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [ADDR_W-1:0] mem_dir,
  output logic [31:0]       mem_dato,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NWORDS = (IMG_W * IMG_H) / 4;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] word_cnt;
  logic [1:0]        lane;
  logic [31:0]       pack;

  // Address and data come straight from registers, so they are stable
  // for as long as the write request is held.
  assign mem_dir  = word_cnt;
  assign mem_dato = pack;

  // Frame sequencer; handshake outputs are registered alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      word_cnt  <= '0;
      lane      <= '0;
      pack      <= '0;
      pix_ready <= 1'b0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= FILL;
            word_cnt  <= '0;
            lane      <= '0;
            pix_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end

        FILL: begin
          // pix_ready is high throughout FILL, so pix_valid alone means accept.
          if (pix_valid) begin
            pack[{lane, 3'b000} +: 8] <= pix_data;
            lane <= lane + 2'd1;
            if (lane == 2'd3) begin
              state     <= WRITE;
              pix_ready <= 1'b0;
              mem_we    <= 1'b1;
            end
          end
        end

        WRITE: begin
          if (mem_ready) begin
            mem_we <= 1'b0;
            if (word_cnt == LAST_WORD) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= FILL;
              word_cnt  <= word_cnt + ADDR_W'(1);
              pix_ready <= 1'b1;
            end
          end
        end

        DONE: begin
          state    <= IDLE;
          done     <= 1'b0;
          word_cnt <= '0;
        end

        default: begin
          state     <= IDLE;
          pix_ready <= 1'b0;
          mem_we    <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Randomized bench for framebuffer_writer: a source model feeds a raster,
// a RAM model captures writes, and contents are compared to the raster packing.
module tb_framebuffer_writer;

  localparam int unsigned IMG_W  = 80;
  localparam int unsigned IMG_H  = 80;
  localparam int unsigned ADDR_W = 11;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NWORDS = NPIX / 4;

  logic              clock = 1'b0;
  logic              reset, start, pix_valid, pix_ready;
  logic [7:0]        pix_data;
  logic [ADDR_W-1:0] mem_dir;
  logic [31:0]       mem_dato;
  logic              mem_we, mem_ready, busy, done;

  always #5 clock = ~clock;

  framebuffer_writer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .start(start),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .mem_dir(mem_dir), .mem_dato(mem_dato), .mem_we(mem_we), .mem_ready(mem_ready),
    .busy(busy), .done(done)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0]  frame [NPIX];
  logic [31:0] mem   [1 << ADDR_W];
  int          n, nwr, ndone;
  bit          acc, wr_pend;
  logic [ADDR_W-1:0] wa;
  logic [31:0]       wd;

  function automatic logic [31:0] ref_word(input int w);
    return {frame[4*w+3], frame[4*w+2], frame[4*w+1], frame[4*w]};
  endfunction

  task automatic new_frame(input bit ramp);
    for (int i = 0; i < NPIX; i++) frame[i] = ramp ? 8'(i) : 8'($urandom);
    for (int w = 0; w < NWORDS; w++) mem[w] = 32'hDEAD_BEEF;
  endtask

  // Apply inputs for the coming edge and note what that edge will transfer.
  task automatic drive(input bit v, input bit r, input bit s, input bit rst);
    reset     = rst;
    start     = s;
    pix_valid = v && (n < NPIX);
    pix_data  = (n < NPIX) ? frame[n] : 8'h00;
    mem_ready = r;
    acc       = pix_valid && pix_ready && !rst;
    wr_pend   = mem_we && mem_ready && !rst;
    wa        = mem_dir;
    wd        = mem_dato;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (acc) n++;
    if (wr_pend) begin
      check("wr_addr", 64'(wa), 64'(nwr));
      mem[wa] = wd;
      nwr++;
    end
    if (done) begin
      ndone++;
      check("busy_at_done", 64'(busy), 64'd0);
    end
    check("ready_we_excl", 64'(pix_ready & mem_we), 64'd0);
  endtask

  task automatic start_frame();
    n = 0; nwr = 0; ndone = 0;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic pump(input int vpct, input int rpct, input int spct, input int stop_words,
                      input int stall_word, input int max_cyc, output int cyc);
    int stall_left;
    bit snap;
    bit v, r, s;
    stall_left = 7;
    snap = 1'b0;
    cyc = 0;
    while (ndone == 0 && nwr < stop_words && cyc < max_cyc) begin
      v = int'($urandom_range(99)) < vpct;
      r = int'($urandom_range(99)) < rpct;
      s = busy && (int'($urandom_range(99)) < spct);
      if (mem_we && int'(mem_dir) == stall_word && !snap) snap = 1'b1;
      if (snap && nwr <= stall_word) begin
        check("stall_we", 64'(mem_we), 64'd1);
        check("stall_dir", 64'(mem_dir), 64'(stall_word));
        check("stall_dato", 64'(mem_dato), 64'(ref_word(stall_word)));
        check("stall_no_ready", 64'(pix_ready), 64'd0);
        if (stall_left > 0) begin
          r = 1'b0;
          stall_left--;
        end
      end
      drive(v, r, s, 1'b0);
      tick();
      cyc++;
    end
  endtask

  task automatic check_words(input string tag, input int count);
    for (int w = 0; w < count; w++) check(tag, 64'(mem[w]), 64'(ref_word(w)));
  endtask

  task automatic settle_after_done();
    repeat (3) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    check("done_once", 64'(ndone), 64'd1);
    check("done_low", 64'(done), 64'd0);
    check("busy_low", 64'(busy), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, we_cyc;
    n = 0; nwr = 0; ndone = 0; acc = 0; wr_pend = 0;
    new_frame(1'b1);
    reset = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = 8'h00; mem_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", 64'({pix_ready, mem_we, busy, done, mem_dir, mem_dato}), 64'd0);

    // Idle with valid asserted: nothing accepted, nothing written.
    repeat (10) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      check("idle_outputs", 64'({pix_ready, mem_we, busy, done, mem_dir, mem_dato}), 64'd0);
    end
    check("idle_consumed", 64'(n), 64'd0);

    // Single word.
    frame[0] = 8'h11; frame[1] = 8'h22; frame[2] = 8'h33; frame[3] = 8'h44;
    start_frame();
    check("start_ready", 64'(pix_ready), 64'd1);
    check("start_busy", 64'(busy), 64'd1);
    we_cyc = 0;
    repeat (10) begin
      drive(n < 4, 1'b1, 1'b0, 1'b0);
      tick();
      if (mem_we) we_cyc++;
    end
    check("w1_count", 64'(nwr), 64'd1);
    check("w1_we_cycles", 64'(we_cyc), 64'd1);
    check("w1_data", 64'(mem[0]), 64'h4433_2211);
    check("w1_back_fill", 64'(pix_ready), 64'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    // Full ramp frame at full rate.
    new_frame(1'b1);
    start_frame();
    pump(100, 100, 0, NWORDS, -1, 20000, cyc);
    check("ramp_cycles", 64'(cyc), 64'd8000);
    check("ramp_writes", 64'(nwr), 64'(NWORDS));
    check("ramp_last_word", 64'(mem[NWORDS-1]), 64'hFFFE_FDFC);
    check_words("ramp_word", NWORDS);
    settle_after_done();

    // Random gaps, stalls, spurious starts and a 7-cycle stall on word 5.
    new_frame(1'b0);
    start_frame();
    pump(70, 60, 5, NWORDS, 5, 60000, cyc);
    check("rand_writes", 64'(nwr), 64'(NWORDS));
    check_words("rand_word", NWORDS);
    settle_after_done();

    // Reset while word 37 is waiting for the RAM.
    new_frame(1'b0);
    start_frame();
    pump(100, 100, 0, 37, -1, 1000, cyc);
    check("pre37_writes", 64'(nwr), 64'd37);
    cyc = 0;
    while (!mem_we && cyc < 20) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      cyc++;
    end
    check("w37_pending", 64'({mem_we, mem_dir}), 64'({1'b1, 11'd37}));
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    check("after_reset", 64'({pix_ready, mem_we, busy, done, mem_dir, mem_dato}), 64'd0);
    check("abandoned_write", 64'(nwr), 64'd37);

    new_frame(1'b0);
    start_frame();
    pump(100, 100, 0, 3, -1, 100, cyc);
    check("reload_writes", 64'(nwr), 64'd3);
    check_words("reload_word", 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/framebuffer_writer.md
# framebuffer_writer

Fills the 80x80 RGB332 image memory that the VGA pixel generator reads. Accepts a stream of 8-bit pixels over a valid/ready handshake and packs four consecutive pixels into one 32-bit word, pixel 0 of a word in bits [7:0]. Writes each word to the image RAM through a write strobe with memory back-pressure. Sits between the pixel source (loader/UART path) and the RAM's write port; the VGA side keeps the read port.

## Interface

- IMG_W, 80, image width in pixels
- IMG_H, 80, image height in pixels; IMG_W*IMG_H must be a multiple of 4 and at most 4*2^ADDR_W
- ADDR_W, 11, word-address width of the image RAM

- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clock
- start  in  1  begin a frame load; honoured only in IDLE
- pix_data  in  8  RGB332 pixel
- pix_valid  in  1  pix_data valid
- pix_ready  out  1  block can accept a pixel this cycle
- mem_dir  out  ADDR_W  word address to write
- mem_dato  out  32  packed word to write
- mem_we  out  1  write request; held until accepted
- mem_ready  in  1  RAM accepts the write at this edge when mem_we=1
- busy  out  1  high in FILL and WRITE
- done  out  1  one-cycle pulse after the last word is accepted

## Operation

- States: IDLE, FILL, WRITE, DONE.
- IDLE: pix_ready=0, mem_we=0, busy=0. start=1 -> FILL; word counter and byte lane cleared to 0.
- FILL: pix_ready=1. Pixel accepted at an edge with pix_valid=1 and pix_ready=1. Accepted pixel goes to lane `lane` of the pack register: lane 0 -> [7:0], lane 1 -> [15:8], lane 2 -> [23:16], lane 3 -> [31:24]. Lane increments mod 4. On acceptance into lane 3 -> WRITE.
- WRITE: pix_ready=0, mem_we=1, mem_dir=word counter, mem_dato=pack register, all stable until acceptance. At an edge with mem_ready=1: if word counter = IMG_W*IMG_H/4 - 1 -> DONE, else word counter +1 and -> FILL.
- DONE: done=1 for exactly one cycle, then -> IDLE. Word counter returns to 0.
- start outside IDLE: ignored. pix_valid outside FILL: ignored, no data consumed.
- Word counter is ADDR_W bits; final address for defaults = 1599 (0x63F); never exceeds it. No wrap mid-frame.
- Pixel n of the frame (raster order, n = y*IMG_W + x) lands in word n>>2, lane n&3.
- Reset in any state: -> IDLE, counters and lane cleared, pack register cleared. A pending write is abandoned and the partial frame is not completed.

## Timing

- Reset values: pix_ready=0, mem_we=0, mem_dir=0, mem_dato=0, busy=0, done=0.
- All outputs registered or decoded from state only; no combinational path from pix_valid or mem_ready to any output.
- start sampled at edge k -> pix_ready=1 from cycle k+1.
- Fourth pixel accepted at edge k -> mem_we=1 in cycle k+1. mem_ready=1 at edge j -> mem_we=0 and pix_ready=1 in cycle j+1 (non-final word).
- Minimum 5 cycles per word with pix_valid and mem_ready held high: 4 FILL cycles + 1 WRITE cycle. Full default frame minimum = 1600*5 = 8000 cycles from first FILL cycle to last accepted write; done is high in the following cycle.
- busy falls in the same cycle that done rises.

## Test plan

- Reset, then idle 10 cycles with pix_valid=1 -> all outputs 0, pix_ready never asserted.
- start; pixels 0x11,0x22,0x33,0x44, mem_ready=1 -> one write: mem_dir=0, mem_dato=0x44332211, mem_we high exactly 1 cycle.
- Full frame of 6400 pixels with value n&0xFF, mem_ready=1 -> 1600 writes at addresses 0..1599 in order, word 1599 = 0xFFFEFDFC, done pulses once, total 8000 cycles.
- mem_ready held low 7 cycles during WRITE -> mem_we, mem_dir, and mem_dato are stable for all 7 cycles; pix_ready=0; no pixel lost when mem_ready rises.
- Random pix_valid gaps and mem_ready stalls over a full frame -> memory model contents match the reference raster; start pulses mid-frame have no effect.
- reset asserted in WRITE for word 37 -> next cycle IDLE, mem_we=0; a following start reloads from address 0.
